// File: rtl/periph_bus_router.sv
// Single-master peripheral router: decodes the host address onto one of NSLV slaves,
// tracks one outstanding transaction and answers decode misses and slave timeouts itself.
module periph_bus_router #(
    parameter int                   NSLV     = 4,
    parameter int                   AW       = 32,
    parameter int                   DW       = 32,
    parameter logic [NSLV*AW-1:0]   SLV_BASE = {32'h3000_0000, 32'h2000_0000,
                                                32'h1000_0000, 32'h0000_0000},
    parameter logic [NSLV*AW-1:0]   SLV_MASK = {NSLV{32'hF000_0000}},
    parameter int                   TMO_CYC  = 256
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 req,
    input  logic                 we,
    input  logic [DW/8-1:0]      be,
    input  logic [AW-1:0]        addr,
    input  logic [DW-1:0]        wdata,
    output logic                 gnt,
    output logic                 rvalid,
    output logic [DW-1:0]        rdata,
    output logic                 err,
    output logic [NSLV-1:0]      s_req,
    output logic                 s_we,
    output logic [DW/8-1:0]      s_be,
    output logic [AW-1:0]        s_addr,
    output logic [DW-1:0]        s_wdata,
    input  logic [NSLV-1:0]      s_gnt,
    input  logic [NSLV-1:0]      s_rvalid,
    input  logic [NSLV*DW-1:0]   s_rdata,
    input  logic [NSLV-1:0]      s_err,
    output logic                 busy,
    output logic [15:0]          err_cnt
);

    localparam int SELW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int TW   = $clog2(TMO_CYC);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DECERR, ST_TMOERR} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SELW-1:0]   r_sel;
    logic [TW-1:0]     r_timer;
    logic [15:0]       r_err_cnt;

    logic [SELW-1:0]   w_sel;
    logic              w_mapped;
    logic              w_gnt;
    logic [NSLV-1:0]   w_sreq;
    logic              w_rvalid;
    logic              w_err;
    logic [DW-1:0]     w_rdata;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    // Scan downwards so the lowest hitting slot is the one left in w_sel.
    always_comb begin
        w_sel    = '0;
        w_mapped = 1'b0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*AW +: AW]) == (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW])) begin
                w_sel    = SELW'(i);
                w_mapped = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = 1'b0;
        w_sreq      = '0;
        w_rvalid    = 1'b0;
        w_err       = 1'b0;
        w_rdata     = '0;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    if (w_mapped) begin
                        w_sreq[w_sel] = 1'b1;
                        w_gnt         = s_gnt[w_sel];
                        if (s_gnt[w_sel]) w_state_nxt = ST_WAIT;
                    end else begin
                        w_gnt       = 1'b1;
                        w_state_nxt = ST_DECERR;
                    end
                end
            end
            ST_WAIT: begin
                if (s_rvalid[r_sel]) begin
                    w_rvalid    = 1'b1;
                    w_rdata     = s_rdata[r_sel*DW +: DW];
                    w_err       = s_err[r_sel];
                    w_state_nxt = ST_IDLE;
                end else if (r_timer == TW'(TMO_CYC - 1)) begin
                    w_state_nxt = ST_TMOERR;
                end
            end
            ST_DECERR, ST_TMOERR: begin
                w_rvalid    = 1'b1;
                w_err       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Outputs are combinational from state, so mask them while reset is held.
        if (Rst) begin
            w_gnt    = 1'b0;
            w_sreq   = '0;
            w_rvalid = 1'b0;
            w_err    = 1'b0;
            w_rdata  = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= ST_IDLE;
            r_sel     <= '0;
            r_timer   <= '0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_err_cnt <= sat_inc(r_err_cnt, w_rvalid & w_err);
            if ((r_state == ST_IDLE) && w_gnt && w_mapped) r_sel <= w_sel;
            if ((r_state == ST_WAIT) && !s_rvalid[r_sel]) r_timer <= r_timer + TW'(1);
            else                                           r_timer <= '0;
        end
    end

    assign gnt     = w_gnt;
    assign s_req   = w_sreq;
    assign rvalid  = w_rvalid;
    assign err     = w_err;
    assign rdata   = w_rdata;
    assign s_we    = we;
    assign s_be    = be;
    assign s_addr  = addr;
    assign s_wdata = wdata;
    assign busy    = (r_state != ST_IDLE) && !Rst;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_periph_bus_router.sv
// Directed bench for periph_bus_router: a transaction-level model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_periph_bus_router;

    localparam int NS  = 4;
    localparam int TMO = 4;
    // Slot 3 deliberately aliases slot 0; 0x3xxx_xxxx is therefore unmapped.
    localparam logic [127:0] BASE = {32'h0000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [127:0] MASK = {4{32'hF000_0000}};

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         req = 1'b0;
    logic         we = 1'b0;
    logic [3:0]   be = 4'h0;
    logic [31:0]  addr = 32'h0;
    logic [31:0]  wdata = 32'h0;
    logic         gnt, rvalid, err, s_we, busy;
    logic [31:0]  rdata, s_addr, s_wdata;
    logic [3:0]   s_req, s_be;
    logic [3:0]   s_gnt = 4'h0;
    logic [3:0]   s_rvalid = 4'h0;
    logic [3:0]   s_err = 4'h0;
    logic [127:0] s_rdata = 128'h0;
    logic [15:0]  err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    bit          m_out = 1'b0;
    bit          m_errresp = 1'b0;
    int          m_slv = 0;
    int          m_age = 0;
    logic [15:0] m_errcnt = 16'h0;

    always #5 Clk = ~Clk;

    periph_bus_router #(
        .NSLV(NS), .AW(32), .DW(32), .SLV_BASE(BASE), .SLV_MASK(MASK), .TMO_CYC(TMO)
    ) dut (
        .Clk(Clk), .Rst(Rst), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
        .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_err(s_err),
        .busy(busy), .err_cnt(err_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if ((a & MASK[i*32 +: 32]) == (BASE[i*32 +: 32] & MASK[i*32 +: 32])) return i;
        return -1;
    endfunction

    // Model: at most one transaction in flight, identified by slave and age since grant.
    always @(negedge Clk) begin : model_cmp
        int          dec;
        logic [3:0]  e_sreq;
        logic        e_gnt, e_rv, e_err, e_busy;
        logic [31:0] e_rd;
        dec = decode(addr);
        e_sreq = 4'h0; e_gnt = 1'b0; e_rv = 1'b0; e_err = 1'b0; e_busy = 1'b0; e_rd = 32'h0;
        if (Rst) begin
        end else if (m_errresp) begin
            e_rv = 1'b1; e_err = 1'b1; e_busy = 1'b1;
        end else if (m_out) begin
            e_busy = 1'b1;
            e_rv   = s_rvalid[m_slv];
            if (e_rv) begin
                e_err = s_err[m_slv];
                e_rd  = s_rdata[m_slv*32 +: 32];
            end
        end else if (req) begin
            if (dec >= 0) begin
                e_sreq[dec] = 1'b1;
                e_gnt = s_gnt[dec];
            end else begin
                e_gnt = 1'b1;
            end
        end
        chk("m_gnt", 64'(gnt), 64'(e_gnt));
        chk("m_sreq", 64'(s_req), 64'(e_sreq));
        chk("m_rvalid", 64'(rvalid), 64'(e_rv));
        chk("m_err", 64'(err), 64'(e_err));
        chk("m_rdata", 64'(rdata), 64'(e_rd));
        chk("m_busy", 64'(busy), 64'(e_busy));
        chk("m_errcnt", 64'(err_cnt), 64'(m_errcnt));
        chk("m_passthru", {s_addr, s_wdata}, {addr, wdata});
        chk("m_passctl", 64'({s_we, s_be}), 64'({we, be}));
        if (Rst) begin
            m_out = 1'b0; m_errresp = 1'b0; m_errcnt = 16'h0;
        end else begin
            if (e_rv && e_err && (m_errcnt != 16'hFFFF)) m_errcnt = m_errcnt + 16'd1;
            if (m_errresp) begin
                m_errresp = 1'b0;
            end else if (m_out) begin
                m_age++;
                if (e_rv) m_out = 1'b0;
                else if (m_age == TMO) begin
                    m_out = 1'b0; m_errresp = 1'b1;
                end
            end else if (e_gnt) begin
                if (dec >= 0) begin
                    m_out = 1'b1; m_slv = dec; m_age = 0;
                end else begin
                    m_errresp = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        // Reset, with a pending unmapped request that must stay silent.
        req = 1'b1; addr = 32'h5000_0000;
        step(); step();
        #1;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_errcnt", 64'(err_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        Rst = 1'b0; req = 1'b0; addr = 32'h0;
        step();

        // Read slave1, response three cycles after grant; slave0 noise ignored.
        req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h1000_0010; s_gnt = 4'b0010;
        #1;
        chk("s1_sreq", 64'(s_req), 64'h2);
        chk("s1_gnt", 64'(gnt), 64'd1);
        step(); req = 1'b0; s_gnt = 4'h0; addr = 32'h0;
        #1; chk("s1_busy", 64'(busy), 64'd1); chk("s1_gnt_wait", 64'(gnt), 64'd0);
        step(); s_rvalid = 4'b0001; s_err = 4'b0001; s_rdata[31:0] = 32'h1111_1111;
        #1; chk("s1_other_rv", 64'(rvalid), 64'd0); chk("s1_other_rd", 64'(rdata), 64'd0);
        step(); s_rvalid = 4'b0010; s_err = 4'h0; s_rdata[63:32] = 32'hDEAD_BEEF;
        #1;
        chk("s1_rvalid", 64'(rvalid), 64'd1);
        chk("s1_rdata", 64'(rdata), 64'hDEAD_BEEF);
        chk("s1_err", 64'(err), 64'd0);
        step(); s_rvalid = 4'h0;
        #1; chk("s1_idle", 64'(busy), 64'd0);
        step();

        // Unmapped write: immediate grant, decode error next cycle.
        req = 1'b1; we = 1'b1; be = 4'h3; addr = 32'h5000_0000; wdata = 32'hA5A5_0001;
        #1; chk("s2_gnt", 64'(gnt), 64'd1); chk("s2_sreq", 64'(s_req), 64'd0);
        step(); req = 1'b0;
        #1;
        chk("s2_rvalid", 64'(rvalid), 64'd1);
        chk("s2_err", 64'(err), 64'd1);
        chk("s2_rdata", 64'(rdata), 64'd0);
        step();
        #1; chk("s2_errcnt", 64'(err_cnt), 64'd1);
        step();

        // Slave2 stalls grant once, then never answers: timeout 5 cycles after grant.
        req = 1'b1; we = 1'b0; addr = 32'h2000_0004; s_gnt = 4'h0;
        #1; chk("s3_nogrant", 64'(gnt), 64'd0); chk("s3_sreq", 64'(s_req), 64'h4);
        step(); s_gnt = 4'b0100;
        #1; chk("s3_gnt", 64'(gnt), 64'd1);
        step(); req = 1'b0; s_gnt = 4'h0; s_rdata[95:64] = 32'h7777_7777;
        for (int k = 0; k < TMO; k++) begin
            #1; chk("s3_wait", 64'(rvalid), 64'd0);
            step();
        end
        #1;
        chk("s3_tmo_rv", 64'(rvalid), 64'd1);
        chk("s3_tmo_err", 64'(err), 64'd1);
        chk("s3_tmo_rd", 64'(rdata), 64'd0);
        step(); s_rvalid = 4'b0100; s_err = 4'b0100;
        #1;
        chk("s3_late_rv", 64'(rvalid), 64'd0);
        chk("s3_errcnt", 64'(err_cnt), 64'd2);
        step(); s_rvalid = 4'h0; s_err = 4'h0;

        // Response arriving on the timer's last cycle wins over the timeout.
        req = 1'b1; addr = 32'h2000_0008; s_gnt = 4'b0100;
        #1; chk("s4_gnt", 64'(gnt), 64'd1);
        step(); req = 1'b0; s_gnt = 4'h0;
        for (int k = 0; k < TMO - 1; k++) begin
            #1; chk("s4_wait", 64'(rvalid), 64'd0);
            step();
        end
        s_rvalid = 4'b0100; s_rdata[95:64] = 32'hCAFE_F00D;
        #1;
        chk("s4_rv", 64'(rvalid), 64'd1);
        chk("s4_err", 64'(err), 64'd0);
        chk("s4_rd", 64'(rdata), 64'hCAFE_F00D);
        step(); s_rvalid = 4'h0;
        #1; chk("s4_after", 64'(rvalid), 64'd0); chk("s4_errcnt", 64'(err_cnt), 64'd2);
        step();

        // Overlapping slots 0 and 3: only slot 0 requested; slot 3 response ignored.
        req = 1'b1; addr = 32'h0000_0100; s_gnt = 4'b1001;
        #1; chk("s5_sreq", 64'(s_req), 64'h1); chk("s5_gnt", 64'(gnt), 64'd1);
        step(); req = 1'b0; s_gnt = 4'h0; s_rvalid = 4'b1000; s_err = 4'b1000;
        s_rdata[127:96] = 32'hBAD0_BAD0;
        #1; chk("s5_s3_rv", 64'(rvalid), 64'd0); chk("s5_s3_err", 64'(err), 64'd0);
        step(); s_rvalid = 4'b0001; s_err = 4'h0; s_rdata[31:0] = 32'h1234_5678;
        #1; chk("s5_rv", 64'(rvalid), 64'd1); chk("s5_rd", 64'(rdata), 64'h1234_5678);
        step(); s_rvalid = 4'h0;

        // Zero-wait slave error at the top of slave1's window.
        req = 1'b1; we = 1'b1; addr = 32'h1FFF_FFFC; s_gnt = 4'b0010;
        #1; chk("s6_sreq", 64'(s_req), 64'h2); chk("s6_gnt", 64'(gnt), 64'd1);
        step(); req = 1'b0; s_gnt = 4'h0; s_rvalid = 4'b0010; s_err = 4'b0010;
        s_rdata[63:32] = 32'h0BAD_0001;
        #1;
        chk("s6_rv", 64'(rvalid), 64'd1);
        chk("s6_err", 64'(err), 64'd1);
        chk("s6_rd", 64'(rdata), 64'h0BAD_0001);
        step(); s_rvalid = 4'h0; s_err = 4'h0;
        #1; chk("s6_errcnt", 64'(err_cnt), 64'd3);
        step();

        // Reset two cycles into WAIT: no response, then a clean new read.
        req = 1'b1; we = 1'b0; addr = 32'h0000_0040; s_gnt = 4'b0001;
        #1; chk("s7_gnt", 64'(gnt), 64'd1);
        step(); req = 1'b0; s_gnt = 4'h0;
        step();
        step(); Rst = 1'b1; s_rvalid = 4'b0001; req = 1'b1; addr = 32'h0000_0080; s_gnt = 4'b0001;
        #1;
        chk("s7_rst_rv", 64'(rvalid), 64'd0);
        chk("s7_rst_gnt", 64'(gnt), 64'd0);
        chk("s7_rst_sreq", 64'(s_req), 64'd0);
        step(); Rst = 1'b0; s_rvalid = 4'h0;
        #1;
        chk("s7_errcnt", 64'(err_cnt), 64'd0);
        chk("s7_new_gnt", 64'(gnt), 64'd1);
        step(); req = 1'b0; s_gnt = 4'h0; s_rvalid = 4'b0001; s_rdata[31:0] = 32'h0000_0080;
        #1; chk("s7_new_rv", 64'(rvalid), 64'd1); chk("s7_new_rd", 64'(rdata), 64'h80);
        step(); s_rvalid = 4'h0;

        // Counter saturation, driven by back-to-back decode errors.
        force dut.r_err_cnt = 16'hFFFD;
        m_errcnt = 16'hFFFD;
        step();
        release dut.r_err_cnt;
        req = 1'b1; we = 1'b1; addr = 32'h3000_0000;
        for (int k = 0; k < 4; k++) begin
            #1; chk("s8_gnt", 64'(gnt), 64'd1);
            step();
            #1; chk("s8_rv", 64'(rvalid), 64'd1); chk("s8_gnt_resp", 64'(gnt), 64'd0);
            step();
        end
        req = 1'b0;
        #1; chk("s8_sat", 64'(err_cnt), 64'hFFFF);
        step();
        #1; chk("s8_hold", 64'(err_cnt), 64'hFFFF);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
